sync_fifo_pro: RTL and testbench
================================

Name: sync_fifo_pro

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's basic FIFO.
- Adds arbitrary (non-power-of-2) depth, occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow errors, synchronous flush, and selectable standard or first-word-fall-through (FWFT) read mode.
- Used as the general buffering element between datapath stages in one clock domain.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 64: number of entries (>=2; need not be a power of 2).
- FWFT, 0: 0 = standard mode, read data registered one cycle after an accepted read; 1 = head word presented combinationally on data_out.
- AF_TH, DEPTH-2: almost_full asserted when count >= AF_TH.
- AE_TH, 2: almost_empty asserted when count <= AE_TH.
- CW, $clog2(DEPTH+1): count width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- write  in  1  push request.
- data_in  in  WIDTH  push data.
- read  in  1  pop request.
- data_out  out  WIDTH  read data.
- rd_valid  out  1  standard mode: data_out updated this cycle; FWFT: equals ~empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  CW  current occupancy.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async assert, sync release): pointers 0, count 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, rd_valid 0, data_out 0. Memory contents not reset.
- Acceptance uses registered state: wr_acc = write & ~full; rd_acc = read & ~empty.
- Pointers wrap explicitly at DEPTH-1 -> 0 (no reliance on power-of-2 rollover).
- count next = count + wr_acc - rd_acc; all flags are registered and derived from next count, so they are valid the cycle after the update.
- Simultaneous read and write:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow set.
  - Empty: write accepted, read rejected, underflow set; no bypass of write data to read data.
- Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr] at the next edge and rd_valid pulses high for that one cycle. Otherwise data_out holds and rd_valid is 0.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] when ~empty, 0 when empty; rd_valid = ~empty.
  - read acts as acknowledge/pop.
  - A written word is visible on data_out the cycle after the write into an empty FIFO.
- overflow/underflow stay set until clr_err or reset. clr_err takes priority over a same-cycle new error (clears).
- flush: highest priority over read/write.
  - Next edge: pointers 0, count 0, empty 1, full 0, flags recomputed (almost_empty 1).
  - Read/write in the same cycle are ignored and do not set error flags.
  - Error flags and standard-mode data_out are unaffected.
- Reset asserted mid-operation returns all state to reset values immediately; partial accesses are discarded.

Test Plan:
- DEPTH=6, FWFT=0: write 0x11..0x16 on consecutive cycles -> full=1 after the 6th edge, count=6, almost_full=1 from count>=4; 7th write -> overflow=1, count stays 6; read 6 -> data_out 0x11..0x16 each one cycle after read with rd_valid pulses; empty=1, count=0.
- DEPTH=6 wrap: write 4, read 4, write 5, read 5 -> data returned in order, pointers cross index 5 -> 0, no flag glitches.
- Simultaneous read/write at count=3 for 10 cycles -> count stays 3, output sequence equals input order; at full -> read accepted, overflow set; at empty -> write accepted, underflow set.
- FWFT=1: write 0xA5 into empty -> next cycle data_out=0xA5, rd_valid=1; read -> empty=1, data_out=0; read while empty -> underflow=1; clr_err -> 0.
- flush at count=5 with write=1 -> next cycle count=0, empty=1, almost_empty=1, overflow unchanged; following write/read pair returns the new word only.
- rst_n asserted low asynchronously mid-burst (between edges) -> outputs reach reset values without waiting for a clock edge; after release, a normal write/read returns correct data.

Source files
------------

// File: rtl/sync_fifo_pro.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_pro
//  Brief    : Single-clock FIFO, arbitrary depth, level flags, sticky errors,
//             synchronous flush, standard or first-word-fall-through read.
//  Revision : 1.0
// ============================================================================
module sync_fifo_pro #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 64,
    parameter  int FWFT  = 0,
    parameter  int AF_TH = DEPTH - 2,
    parameter  int AE_TH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             write,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] C_PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF_TH    = CW'(AF_TH);
    localparam logic [CW-1:0] C_AE_TH    = CW'(AE_TH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CW-1:0]    w_count_nxt;
    logic [PW-1:0]    w_wr_ptr_inc;
    logic [PW-1:0]    w_rd_ptr_inc;

    // Acceptance is judged on registered flags; flush suppresses both sides.
    always_comb begin
        w_wr_acc     = write & ~r_full & ~flush;
        w_rd_acc     = read & ~r_empty & ~flush;
        w_count_nxt  = flush ? '0 : (r_count + CW'(w_wr_acc) - CW'(w_rd_acc));
        w_wr_ptr_inc = (r_wr_ptr == C_PTR_LAST) ? '0 : (r_wr_ptr + PW'(1));
        w_rd_ptr_inc = (r_rd_ptr == C_PTR_LAST) ? '0 : (r_rd_ptr + PW'(1));
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
                if (w_rd_acc) r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == C_DEPTH);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= C_AF_TH);
            r_almost_empty <= (w_count_nxt <= C_AE_TH);
        end
    end

    // Flush-cycle requests are dropped silently, so they never raise errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write & r_full & ~flush)  r_overflow  <= 1'b1;
            if (read & r_empty & ~flush)  r_underflow <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_empty ? '0 : r_mem[r_rd_ptr];
            assign rd_valid = ~r_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_data_out;
            logic             r_rd_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_data_out;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_pro.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_pro
//  Brief    : Directed bench for sync_fifo_pro, standard and FWFT instances.
//  Revision : 1.0
// ============================================================================
module tb_sync_fifo_pro;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;

    logic             s_flush, s_write, s_read, s_clr;
    logic [WIDTH-1:0] s_din, s_dout;
    logic             s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [CW-1:0]    s_count;

    logic             f_flush, f_write, f_read, f_clr;
    logic [WIDTH-1:0] f_din, f_dout;
    logic             f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0]    f_count;

    int n_cmp;
    int n_fail;

    sync_fifo_pro #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .write(s_write),
        .data_in(s_din), .read(s_read), .data_out(s_dout), .rd_valid(s_rv),
        .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
        .underflow(s_unf), .clr_err(s_clr)
    );

    sync_fifo_pro #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .write(f_write),
        .data_in(f_din), .read(f_read), .data_out(f_dout), .rd_valid(f_rv),
        .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
        .underflow(f_unf), .clr_err(f_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] e;

        n_cmp  = 0;
        n_fail = 0;
        {s_flush, s_write, s_read, s_clr, s_din} = '0;
        {f_flush, f_write, f_read, f_clr, f_din} = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();

        chk("rst_empty",  32'(s_empty), 32'd1);
        chk("rst_full",   32'(s_full),  32'd0);
        chk("rst_af",     32'(s_af),    32'd0);
        chk("rst_ae",     32'(s_ae),    32'd1);
        chk("rst_count",  32'(s_count), 32'd0);
        chk("rst_ovf",    32'(s_ovf),   32'd0);
        chk("rst_unf",    32'(s_unf),   32'd0);
        chk("rst_rv",     32'(s_rv),    32'd0);
        chk("rst_dout",   32'(s_dout),  32'd0);
        chk("rst_f_dout", 32'(f_dout),  32'd0);
        chk("rst_f_rv",   32'(f_rv),    32'd0);
        rst_n = 1'b1;
        step();

        // Fill to full, then one extra write to raise overflow.
        s_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_din = 8'(8'h11 + i);
            step();
            chk("fill_count", 32'(s_count), 32'(i + 1));
            chk("fill_af",    32'(s_af),    32'((i + 1) >= 4));
            chk("fill_ae",    32'(s_ae),    32'((i + 1) <= 2));
            chk("fill_full",  32'(s_full),  32'(i == 5));
        end
        s_din = 8'h77;
        step();
        chk("ovf_set",   32'(s_ovf),   32'd1);
        chk("ovf_count", 32'(s_count), 32'd6);
        s_write = 1'b0;
        s_clr   = 1'b1;
        step();
        chk("ovf_clr", 32'(s_ovf), 32'd0);
        s_clr = 1'b0;

        s_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("drain_dout", 32'(s_dout), 32'(8'h11 + i));
            chk("drain_rv",   32'(s_rv),   32'd1);
        end
        s_read = 1'b0;
        step();
        chk("drain_rv_low", 32'(s_rv),    32'd0);
        chk("drain_hold",   32'(s_dout),  32'h16);
        chk("drain_empty",  32'(s_empty), 32'd1);
        chk("drain_count",  32'(s_count), 32'd0);

        s_read = 1'b1;
        step();
        chk("unf_set",  32'(s_unf), 32'd1);
        chk("unf_rv",   32'(s_rv),  32'd0);
        s_read = 1'b0;
        s_clr  = 1'b1;
        step();
        chk("unf_clr", 32'(s_unf), 32'd0);
        s_clr = 1'b0;

        // Wrap: write 4/read 4, then write 5/read 5 crosses index 5 -> 0.
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            n = (pass == 0) ? 4 : 5;
            s_write = 1'b1;
            for (int i = 0; i < n; i++) begin
                s_din = 8'(8'h20 + 16 * pass + i);
                step();
            end
            s_write = 1'b0;
            chk("wrap_count", 32'(s_count), 32'(n));
            s_read = 1'b1;
            for (int i = 0; i < n; i++) begin
                step();
                chk("wrap_dout", 32'(s_dout), 32'(8'h20 + 16 * pass + i));
                chk("wrap_full", 32'(s_full), 32'd0);
            end
            s_read = 1'b0;
            step();
            chk("wrap_empty", 32'(s_empty), 32'd1);
        end

        // Concurrent read/write at count 3.
        s_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_din = 8'(8'h40 + i);
            exp_q.push_back(s_din);
            step();
        end
        s_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_din = 8'(8'h50 + i);
            exp_q.push_back(s_din);
            step();
            e = exp_q.pop_front();
            chk("rw_dout",  32'(s_dout),  32'(e));
            chk("rw_count", 32'(s_count), 32'd3);
        end
        s_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_q.pop_front();
            chk("rw_tail", 32'(s_dout), 32'(e));
        end
        s_read = 1'b0;
        step();
        chk("rw_empty", 32'(s_empty), 32'd1);

        // Concurrent read/write at full and at empty.
        s_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_din = 8'(8'h60 + i);
            step();
        end
        s_din  = 8'h99;
        s_read = 1'b1;
        step();
        chk("full_rw_dout",  32'(s_dout),  32'h60);
        chk("full_rw_ovf",   32'(s_ovf),   32'd1);
        chk("full_rw_count", 32'(s_count), 32'd5);
        s_write = 1'b0;
        s_read  = 1'b0;
        s_clr   = 1'b1;
        step();
        s_clr  = 1'b0;
        s_read = 1'b1;
        for (int i = 1; i < 6; i++) begin
            step();
            chk("full_rw_drain", 32'(s_dout), 32'(8'h60 + i));
        end
        s_write = 1'b1;
        s_din   = 8'hAB;
        step();
        chk("empty_rw_count", 32'(s_count), 32'd1);
        chk("empty_rw_unf",   32'(s_unf),   32'd1);
        chk("empty_rw_rv",    32'(s_rv),    32'd0);
        chk("empty_rw_nobyp", 32'(s_dout),  32'h65);
        s_write = 1'b0;
        step();
        chk("empty_rw_dout", 32'(s_dout), 32'hAB);
        s_read = 1'b0;
        s_clr  = 1'b1;
        step();
        s_clr = 1'b0;

        // Flush at count 5 with overflow pending.
        s_write = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_din = 8'(8'hC0 + i);
            step();
        end
        s_write = 1'b0;
        s_read  = 1'b1;
        step();
        s_read = 1'b0;
        chk("pre_flush_count", 32'(s_count), 32'd5);
        s_flush = 1'b1;
        s_write = 1'b1;
        s_read  = 1'b1;
        s_din   = 8'hEE;
        step();
        {s_flush, s_write, s_read} = '0;
        chk("flush_count", 32'(s_count), 32'd0);
        chk("flush_empty", 32'(s_empty), 32'd1);
        chk("flush_ae",    32'(s_ae),    32'd1);
        chk("flush_af",    32'(s_af),    32'd0);
        chk("flush_ovf",   32'(s_ovf),   32'd1);
        chk("flush_unf",   32'(s_unf),   32'd0);
        chk("flush_dout",  32'(s_dout),  32'hC0);
        chk("flush_rv",    32'(s_rv),    32'd0);
        s_write = 1'b1;
        s_din   = 8'hD1;
        step();
        s_write = 1'b0;
        s_read  = 1'b1;
        step();
        s_read = 1'b0;
        chk("post_flush_dout",  32'(s_dout),  32'hD1);
        chk("post_flush_rv",    32'(s_rv),    32'd1);
        chk("post_flush_empty", 32'(s_empty), 32'd1);

        // FWFT instance.
        f_write = 1'b1;
        f_din   = 8'hA5;
        step();
        f_write = 1'b0;
        chk("fw_dout",  32'(f_dout),  32'hA5);
        chk("fw_rv",    32'(f_rv),    32'd1);
        chk("fw_empty", 32'(f_empty), 32'd0);
        f_read = 1'b1;
        step();
        f_read = 1'b0;
        chk("fw_pop_empty", 32'(f_empty), 32'd1);
        chk("fw_pop_dout",  32'(f_dout),  32'd0);
        chk("fw_pop_rv",    32'(f_rv),    32'd0);
        f_read = 1'b1;
        step();
        f_read = 1'b0;
        chk("fw_unf", 32'(f_unf), 32'd1);
        f_clr = 1'b1;
        step();
        f_clr = 1'b0;
        chk("fw_unf_clr", 32'(f_unf), 32'd0);
        f_write = 1'b1;
        f_din   = 8'hB1;
        step();
        f_din = 8'hB2;
        step();
        f_write = 1'b0;
        chk("fw_head1", 32'(f_dout), 32'hB1);
        f_read = 1'b1;
        step();
        chk("fw_head2", 32'(f_dout), 32'hB2);
        step();
        f_read = 1'b0;
        chk("fw_drained", 32'(f_empty), 32'd1);

        // Asynchronous reset between edges, mid-burst.
        s_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_din = 8'(8'h71 + i);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(s_count), 32'd0);
        chk("arst_empty", 32'(s_empty), 32'd1);
        chk("arst_ae",    32'(s_ae),    32'd1);
        chk("arst_ovf",   32'(s_ovf),   32'd0);
        chk("arst_dout",  32'(s_dout),  32'd0);
        s_write = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        s_write = 1'b1;
        s_din   = 8'h5A;
        step();
        s_write = 1'b0;
        s_read  = 1'b1;
        step();
        s_read = 1'b0;
        chk("arst_after_dout",  32'(s_dout),  32'h5A);
        chk("arst_after_count", 32'(s_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
